// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the memory-port arbiter and its helpers.
package mem_arb_pkg;

  localparam int unsigned DEF_NUM_REQ = 3;
  localparam int unsigned DEF_INW     = 512;
  localparam int unsigned DEF_ADDRW   = 32;
  localparam int unsigned DEF_TIMEOUT = 255;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arb_state_t;

  // Index width for an n-entry one-hot vector; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: grants the first set request at or
// after the pointer, wrapping past the top index back to zero.
module rr_pick
  import mem_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned IDXW    = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDXW-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDXW-1:0]    grant_idx,
  output logic               any
);

  int unsigned cand;
  logic        found;

  // Scan NUM_REQ positions starting at ptr; first set request wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      cand = 32'(ptr) + off;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!found && req[cand[IDXW-1:0]]) begin
        grant[cand[IDXW-1:0]] = 1'b1;
        grant_idx             = cand[IDXW-1:0];
        found                 = 1'b1;
      end
    end
  end

  assign any = found;

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter/sequencer sharing one memory port between NUM_REQ
// requesters, one line-wide transaction at a time, with a WAIT watchdog.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned INW     = DEF_INW,
  parameter int unsigned ADDRW   = DEF_ADDRW,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ-1:0]       req_write,
  input  logic [NUM_REQ*ADDRW-1:0] req_addr,
  input  logic [NUM_REQ*INW-1:0]   req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [NUM_REQ-1:0]       resp_valid,
  output logic                     resp_err,
  output logic [INW-1:0]           resp_data,
  output logic                     mem_req,
  output logic                     mem_write,
  output logic [ADDRW-1:0]         mem_addr,
  output logic [INW-1:0]           mem_data_in,
  input  logic                     mem_valid_out,
  input  logic [INW-1:0]           mem_data_out
);

  localparam int unsigned IDXW = idx_width(NUM_REQ);
  localparam int unsigned CW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT);

  if (TIMEOUT == 0) begin : g_bad_timeout
    $error("mem_arbiter: TIMEOUT must be nonzero");
  end

  arb_state_t       state_q, state_d;
  logic [IDXW-1:0]  ptr_q, ptr_d;
  logic [IDXW-1:0]  owner_q, owner_d;
  logic             wr_q, wr_d;
  logic [ADDRW-1:0] addr_q, addr_d;
  logic [INW-1:0]   wdata_q, wdata_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    cnt_inc;
  logic [INW-1:0]   rdata_q, rdata_d;
  logic             err_q, err_d;

  logic [NUM_REQ-1:0] pick_grant;
  logic [IDXW-1:0]    pick_idx;
  logic               pick_any;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDXW    (IDXW)
  ) u_pick (
    .req       (req_valid),
    .ptr       (ptr_q),
    .grant     (pick_grant),
    .grant_idx (pick_idx),
    .any       (pick_any)
  );

  // State and transaction registers; reset aborts any transaction silently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Next-state, capture and per-requester handshake logic.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    req_ready  = '0;
    resp_valid = '0;
    cnt_inc    = cnt_q + 1'b1;

    case (state_q)
      IDLE: begin
        // Gated by rst so every output reads zero while reset is held.
        if (!rst) req_ready = pick_grant;
        if (pick_any) begin
          owner_d = pick_idx;
          wr_d    = req_write[pick_idx];
          addr_d  = req_addr[pick_idx*ADDRW +: ADDRW];
          wdata_d = req_data[pick_idx*INW +: INW];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (mem_valid_out) begin
          rdata_d = mem_data_out;
          err_d   = 1'b0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TO_LAST) begin
            rdata_d = '0;
            err_d   = 1'b1;
            state_d = RESP;
          end
        end
      end
      RESP: begin
        resp_valid[owner_q] = 1'b1;
        ptr_d   = (owner_q == IDXW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_req     = (state_q == ISSUE) || (state_q == WAIT);
  assign mem_write   = wr_q;
  assign mem_addr    = addr_q;
  assign mem_data_in = wdata_q;
  assign resp_data   = rdata_q;
  assign resp_err    = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: arbitration table, directed corner
// sequences and randomized transactions against a transaction-level model.
module tb_mem_arbiter;

  localparam int NREQ = 3;
  localparam int INW  = 512;
  localparam int AW   = 32;
  localparam int TMO  = 8;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_write;
  logic [NREQ*AW-1:0]    req_addr;
  logic [NREQ*INW-1:0]   req_data;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       resp_valid;
  logic                  resp_err;
  logic [INW-1:0]        resp_data;
  logic                  mem_req;
  logic                  mem_write;
  logic [AW-1:0]         mem_addr;
  logic [INW-1:0]        mem_data_in;
  logic                  mem_valid_out;
  logic [INW-1:0]        mem_data_out;

  mem_arbiter #(
    .NUM_REQ (NREQ),
    .INW     (INW),
    .ADDRW   (AW),
    .TIMEOUT (TMO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_write     (req_write),
    .req_addr      (req_addr),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .resp_valid    (resp_valid),
    .resp_err      (resp_err),
    .resp_data     (resp_data),
    .mem_req       (mem_req),
    .mem_write     (mem_write),
    .mem_addr      (mem_addr),
    .mem_data_in   (mem_data_in),
    .mem_valid_out (mem_valid_out),
    .mem_data_out  (mem_data_out)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int model_ptr = 0;

  typedef struct {
    logic [NREQ-1:0] valid;
    logic [NREQ-1:0] ready;
  } vec_t;

  task automatic chk(input string name, input logic [INW-1:0] act, input logic [INW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Round-robin rule: first valid index scanning upward from p with wrap.
  function automatic int pick(input logic [NREQ-1:0] v, input int p);
    int idx;
    for (int k = 0; k < NREQ; k++) begin
      idx = (p + k) % NREQ;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [INW-1:0] rand_line();
    logic [INW-1:0] r;
    r = '0;
    for (int i = 0; i < INW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Never more than one grant or one response at a time.
  always @(negedge clk) begin
    n_cmp++;
    if (!$onehot0(req_ready)) begin
      n_bad++;
      $display("FAIL ready_onehot: got %b expected at most one bit", req_ready);
    end
    n_cmp++;
    if (!$onehot0(resp_valid)) begin
      n_bad++;
      $display("FAIL resp_onehot: got %b expected at most one bit", resp_valid);
    end
  end

  // Runs one transaction starting in an IDLE cycle with inputs already driven.
  // ack_at: WAIT cycle (1-based) carrying mem_valid_out; 0 or > TMO = never.
  // scramble: 0 keep inputs, 1 randomize inputs and strobe a stray ack in
  // ISSUE, 2 move requester 0 address to 0x100.
  task automatic run_txn(input int exp_w, input int ack_at, input int scramble,
                         input logic [INW-1:0] mdata);
    int              w;
    logic            ewr;
    logic [AW-1:0]   eaddr;
    logic [INW-1:0]  ewdata;
    logic [INW-1:0]  erdata;
    logic            eerr;
    logic [NREQ-1:0] oh;
    w = (exp_w >= 0) ? exp_w : pick(req_valid, model_ptr);
    if (w < 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL run_txn: got no valid request expected at least one");
      return;
    end
    ewr    = req_write[w];
    eaddr  = req_addr[w*AW +: AW];
    ewdata = req_data[w*INW +: INW];
    oh     = '0;
    oh[w]  = 1'b1;
    mem_valid_out = 1'b0;
    #1;
    chk("ready_idle", req_ready, oh);
    chk("idle_memreq", mem_req, 0);
    tick();
    if (scramble == 1) begin
      req_valid     = NREQ'($urandom);
      req_write     = NREQ'($urandom);
      req_addr      = {$urandom, $urandom, $urandom};
      req_data      = {rand_line(), rand_line(), rand_line()};
      mem_valid_out = 1'b1;
      mem_data_out  = rand_line();
    end else if (scramble == 2) begin
      req_addr[0 +: AW] = 32'h100;
    end
    #1;
    chk("issue_memreq", mem_req, 1);
    chk("issue_addr", mem_addr, eaddr);
    chk("issue_write", mem_write, ewr);
    chk("issue_wdata", mem_data_in, ewdata);
    chk("issue_ready", req_ready, 0);
    chk("issue_resp", resp_valid, 0);
    tick();
    for (int c = 1; c <= TMO; c++) begin
      mem_valid_out = (c == ack_at);
      mem_data_out  = (c == ack_at) ? mdata : rand_line();
      #1;
      chk("wait_memreq", mem_req, 1);
      chk("wait_addr", mem_addr, eaddr);
      chk("wait_write", mem_write, ewr);
      chk("wait_wdata", mem_data_in, ewdata);
      chk("wait_resp", resp_valid, 0);
      chk("wait_ready", req_ready, 0);
      tick();
      if (c == ack_at) break;
    end
    mem_valid_out = 1'b0;
    eerr   = !(ack_at >= 1 && ack_at <= TMO);
    erdata = eerr ? '0 : mdata;
    chk("resp_valid", resp_valid, oh);
    chk("resp_err", resp_err, eerr);
    chk("resp_data", resp_data, erdata);
    chk("resp_memreq", mem_req, 0);
    chk("resp_ready", req_ready, 0);
    model_ptr = (w + 1) % NREQ;
    tick();
    chk("after_resp", resp_valid, 0);
    chk("hold_data", resp_data, erdata);
    chk("hold_err", resp_err, eerr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected to finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    vec_t           tbl [8];
    logic [INW-1:0] line;

    tbl[0] = '{3'b000, 3'b000};
    tbl[1] = '{3'b001, 3'b001};
    tbl[2] = '{3'b010, 3'b010};
    tbl[3] = '{3'b011, 3'b001};
    tbl[4] = '{3'b100, 3'b100};
    tbl[5] = '{3'b101, 3'b001};
    tbl[6] = '{3'b110, 3'b010};
    tbl[7] = '{3'b111, 3'b001};

    rst           = 1'b1;
    req_valid     = '0;
    req_write     = '0;
    req_addr      = '0;
    req_data      = '0;
    mem_valid_out = 1'b0;
    mem_data_out  = '0;
    #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_resp", resp_valid, 0);
    chk("rst_err", resp_err, 0);
    chk("rst_data", resp_data, 0);
    chk("rst_memreq", mem_req, 0);
    chk("rst_write", mem_write, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_data_in, 0);
    tick();
    tick();
    rst = 1'b0;

    // Arbitration from the post-reset pointer (0), one cycle per vector.
    for (int i = 0; i < 8; i++) begin
      tick();
      req_valid = tbl[i].valid;
      #1;
      chk("tbl_ready", req_ready, tbl[i].ready);
      chk("tbl_memreq", mem_req, 0);
      req_valid = '0;
    end
    tick();

    // Contention: all three request continuously, immediate acks.
    req_valid = 3'b111;
    req_write = 3'b000;
    req_addr  = {32'h300, 32'h200, 32'h100};
    run_txn(0, 1, 0, rand_line());
    run_txn(1, 1, 0, rand_line());
    run_txn(2, 1, 0, rand_line());
    run_txn(0, 1, 0, rand_line());

    // Single read from requester 1, ack two cycles after mem_req.
    req_valid = 3'b010;
    req_write = 3'b000;
    req_addr  = {32'h0, 32'h40, 32'h0};
    line = '0;
    line[INW-1 -: 16] = 16'hDEAD;
    line[15:0]        = 16'hBEEF;
    run_txn(-1, 2, 0, line);

    // Write from requester 2, acked on the third WAIT cycle.
    req_valid = 3'b100;
    req_write = 3'b100;
    req_addr  = {32'h80, 32'h0, 32'h0};
    req_data  = '0;
    req_data[2*INW +: INW] = 512'h1234;
    run_txn(-1, 3, 0, rand_line());

    // Address change after accept must not reach the memory port.
    req_valid = 3'b001;
    req_write = 3'b000;
    req_addr  = {32'h0, 32'h0, 32'h40};
    run_txn(-1, 2, 2, rand_line());

    // Memory never acks: watchdog fires after TMO WAIT cycles.
    req_valid = 3'b010;
    req_addr  = {32'h0, 32'h55, 32'h0};
    run_txn(-1, 0, 0, rand_line());
    // Next requester then served normally.
    req_valid = 3'b101;
    req_addr  = {32'h66, 32'h0, 32'h77};
    run_txn(-1, 2, 0, rand_line());
    // Ack arriving on the last allowed WAIT cycle beats the watchdog.
    req_valid = 3'b001;
    run_txn(-1, TMO, 0, rand_line());

    // Reset asserted mid-WAIT aborts the transaction silently.
    req_valid = 3'b100;
    req_write = 3'b000;
    req_addr  = {32'h99, 32'h0, 32'h0};
    #1;
    chk("prerst_ready", req_ready, 3'b100);
    tick();
    req_valid = 3'b111;
    tick();
    tick();
    chk("prerst_memreq", mem_req, 1);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_memreq", mem_req, 0);
    chk("midrst_resp", resp_valid, 0);
    chk("midrst_ready", req_ready, 0);
    chk("midrst_addr", mem_addr, 0);
    chk("midrst_err", resp_err, 0);
    model_ptr = 0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("inrst_resp", resp_valid, 0);
      chk("inrst_memreq", mem_req, 0);
    end
    rst = 1'b0;
    #1;
    chk("postrst_ready", req_ready, 3'b001);
    chk("postrst_resp", resp_valid, 0);
    run_txn(-1, 1, 0, rand_line());

    // Randomized transactions against the round-robin model.
    for (int t = 0; t < 40; t++) begin
      req_valid = NREQ'($urandom_range(1, 7));
      req_write = NREQ'($urandom);
      req_addr  = {$urandom, $urandom, $urandom};
      req_data  = {rand_line(), rand_line(), rand_line()};
      run_txn(-1, int'($urandom_range(0, TMO + 2)), int'($urandom_range(0, 1)), rand_line());
    end

    req_valid = '0;
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Round-robin arbiter and sequencer that shares the single Memory/DataCache port between NUM_REQ requesters: instruction fetch, data load/store, and host DMA.
- Accepts one line-wide read or write at a time, holds the memory inputs stable until the memory acknowledges, then returns read data or a write ack to the owning requester.
- Includes a watchdog so a hung memory transaction cannot lock out every requester.

Parameters:
- NUM_REQ, 3, number of requesters; index 0 has the highest priority after reset.
- INW, 512, memory line width in bits.
- ADDRW, 32, address width.
- TIMEOUT, 255, maximum cycles in WAIT before the transaction is aborted with an error.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_write  in  NUM_REQ  1=write, 0=read.
- req_addr  in  NUM_REQ*ADDRW  packed addresses; requester i uses bits [i*ADDRW +: ADDRW].
- req_data  in  NUM_REQ*INW  packed write data.
- req_ready  out  NUM_REQ  one-hot accept; a transfer occurs when req_valid[i] & req_ready[i].
- resp_valid  out  NUM_REQ  one-hot single-cycle response pulse.
- resp_err  out  1  qualifies resp_valid; 1 = timed out.
- resp_data  out  INW  read data, shared by all requesters, valid with resp_valid.
- mem_req  out  1  memory request strobe, held for the whole transaction.
- mem_write  out  1  to Memory write.
- mem_addr  out  ADDRW  to Memory addr_in.
- mem_data_in  out  INW  to Memory data_in.
- mem_valid_out  in  1  from Memory valid_out.
- mem_data_out  in  INW  from Memory data_out.

Behaviour:
- Reset values:
  - All outputs 0.
  - State = IDLE, round-robin pointer = 0, timeout counter = 0.
  - Reset asserted mid-transaction aborts it silently: no resp_valid, and mem_req drops immediately.
- IDLE:
  - req_ready is combinational: one-hot on the first requester with req_valid set, scanning from the pointer upward with wrap-around.
  - On a transfer, register the winner's index, write flag, address and data; next state ISSUE.
  - No valid request: req_ready = 0 and the state stays IDLE.
- ISSUE (1 cycle):
  - mem_req = 1, mem_write/mem_addr/mem_data_in driven from the registers.
  - Timeout counter cleared; next state WAIT.
- WAIT:
  - mem_req and the memory inputs are held unchanged.
  - mem_valid_out = 1: capture mem_data_out into resp_data, resp_err = 0, next state RESP.
  - Otherwise the counter increments. When it reaches TIMEOUT: resp_err = 1, resp_data = 0, next state RESP.
  - mem_valid_out seen while in ISSUE or IDLE is ignored.
- RESP (1 cycle):
  - resp_valid[owner] = 1; mem_req = 0.
  - Pointer = owner+1, wrapping to 0 at NUM_REQ.
  - Next state IDLE.
  - resp_data and resp_err hold their values until the next RESP.
- Writes also wait for mem_valid_out as their ack; resp_data on a write response is don't-care but must be deterministic (the captured mem_data_out).
- Latency:
  - Transfer at cycle T, mem_req rises at T+1.
  - mem_valid_out at cycle W ≥ T+2 gives resp_valid at W+1.
  - Best case is 3 cycles from accept to response.
  - Back-to-back throughput is at most one transaction per 4 cycles.
- Requester inputs are sampled only at the transfer cycle. Later changes to req_* do not affect an in-flight transaction.
- req_ready is 0 in every state except IDLE, so at most one transaction is outstanding.
- Fairness: a continuously requesting port waits for at most NUM_REQ-1 other transactions.
- Counter width is $clog2(TIMEOUT+1). TIMEOUT=0 is illegal (elaboration assertion).

Decomposition:
- Package mem_arb_pkg holds:
  - typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;
  - shared INW/ADDRW defaults.
- Sub-module rr_pick (NUM_REQ): combinational round-robin one-hot selector (req vector and pointer in; grant one-hot and index out). Reusable by other shared-resource arbiters.

Test Plan:
- Single read: req_valid[1], addr 0x40. Memory returns 0xDEAD…BEEF with valid 2 cycles after mem_req → mem_addr=0x40, mem_write=0; resp_valid=3'b010 with that data; resp_err=0.
- Contention: all three request from reset, each ack immediate → grant order 0,1,2,0. Each response reaches its own port only; req_ready never multi-hot.
- Write ack: requester 2 writes 0x1234 to addr 0x80 → mem_data_in=0x1234 and mem_write=1 held stable through WAIT; resp_valid[2] one cycle after mem_valid_out.
- Timeout: TIMEOUT=8, memory never acks → resp_valid pulses with resp_err=1 exactly 8 WAIT cycles later. The next requester is then served normally.
- Reset mid-WAIT: assert rst during WAIT → mem_req=0 asynchronously, no resp_valid. After release, requester 0 wins first.
- Input stability: change req_addr[0] from 0x40 to 0x100 after accept → mem_addr stays 0x40 until RESP.
